// File: rtl/conbus_pkg.sv
// Shared constants and helpers for the 8-master Wishbone interconnect.
package conbus_pkg;

    localparam int NMASTERS        = 8;
    localparam int IDX_W           = 3;
    localparam int DEFAULT_TIMEOUT = 1024;

    // Highest set bit wins, so a malformed grant still maps to a stable index.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NMASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/conbus_wdt.sv
// Bus watchdog: counts stalled strobe cycles, fires a one-cycle abort and
// records how many aborts happened and which master caused the last one.
module conbus_wdt
    import conbus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb,
    input  logic             ack,
    input  logic             err,
    input  logic             gnt_changed,
    input  logic [IDX_W-1:0] g,
    output logic             wdt_fire,
    output logic [7:0]       wdt_cnt,
    output logic [IDX_W-1:0] wdt_last
);

    logic [CNT_W-1:0] cnt;
    logic             stalled;

    assign stalled = stb & ~ack & ~err & ~gnt_changed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wdt_fire <= 1'b0;
            wdt_cnt  <= '0;
            wdt_last <= '0;
        end else begin
            wdt_fire <= 1'b0;
            if (stalled) begin
                // Firing on the TIMEOUT-th stalled cycle ends the transfer
                // exactly TIMEOUT cycles after the strobe rose.
                if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    wdt_fire <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            if (wdt_fire) begin
                wdt_last <= g;
                if (wdt_cnt != 8'hFF) wdt_cnt <= wdt_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/conbus_mmux.sv
// Master-side mux of the shared Wishbone bus: builds arbiter requests, routes
// the granted master to the slave bus and returns ack/err, with watchdog masking.
module conbus_mmux
    import conbus_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 11
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [NMASTERS*ADR_W-1:0]    m_adr,
    input  logic [NMASTERS*DAT_W-1:0]    m_dat_w,
    input  logic [NMASTERS*DAT_W/8-1:0]  m_sel,
    input  logic [NMASTERS-1:0]          m_we,
    input  logic [NMASTERS-1:0]          m_cyc,
    input  logic [NMASTERS-1:0]          m_stb,
    output logic [DAT_W-1:0]             m_dat_r,
    output logic [NMASTERS-1:0]          m_ack,
    output logic [NMASTERS-1:0]          m_err,
    output logic [NMASTERS-1:0]          req,
    input  logic [NMASTERS-1:0]          gnt,
    output logic [ADR_W-1:0]             s_adr,
    output logic [DAT_W-1:0]             s_dat_w,
    output logic [DAT_W/8-1:0]           s_sel,
    output logic                         s_we,
    output logic                         s_cyc,
    output logic                         s_stb,
    input  logic [DAT_W-1:0]             s_dat_r,
    input  logic                         s_ack,
    input  logic                         s_err,
    output logic [7:0]                   wdt_cnt,
    output logic [IDX_W-1:0]             wdt_last
);

    localparam int SEL_W = DAT_W / 8;

    logic [NMASTERS-1:0] mask;
    logic [NMASTERS-1:0] gnt_q;
    logic [NMASTERS-1:0] mask_set;
    logic                gnt_ok;
    logic                gnt_changed;
    logic                wdt_fire;
    logic [IDX_W-1:0]    g;

    assign gnt_ok      = ($countones(gnt) == 1);
    assign g           = onehot_to_idx(gnt);
    assign gnt_changed = (gnt != gnt_q);

    assign req     = m_cyc & ~mask;
    assign m_dat_r = s_dat_r;

    // Forward path: everything stays zero unless the grant is a clean one-hot.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        if (gnt_ok) begin
            s_adr   = m_adr[int'(g)*ADR_W +: ADR_W];
            s_dat_w = m_dat_w[int'(g)*DAT_W +: DAT_W];
            s_sel   = m_sel[int'(g)*SEL_W +: SEL_W];
            s_we    = m_we[g];
            s_cyc   = m_cyc[g] & ~mask[g];
            s_stb   = m_cyc[g] & ~mask[g] & m_stb[g] & ~wdt_fire;
        end
    end

    // A watchdog abort overrides a late slave ack, which is dropped.
    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (gnt_ok) begin
            if (s_ack && !wdt_fire) m_ack = gnt;
            if (s_err || wdt_fire)  m_err = gnt;
        end
    end

    assign mask_set = (wdt_fire && gnt_ok) ? gnt : '0;

    // A mask holds only while the offending master keeps cyc asserted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mask  <= '0;
            gnt_q <= '0;
        end else begin
            mask  <= (mask | mask_set) & m_cyc;
            gnt_q <= gnt;
        end
    end

    conbus_wdt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdt (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .stb         (s_stb),
        .ack         (s_ack),
        .err         (s_err),
        .gnt_changed (gnt_changed),
        .g           (g),
        .wdt_fire    (wdt_fire),
        .wdt_cnt     (wdt_cnt),
        .wdt_last    (wdt_last)
    );

endmodule

// File: tb/tb_conbus_mmux.sv
// Randomized and directed bench for conbus_mmux against a per-master
// reference model of requests, masking, routing and the stall watchdog.
module tb_conbus_mmux;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = DAT_W / 8;
    localparam int TMO   = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [ADR_W-1:0] adr_a [8];
    logic [DAT_W-1:0] dat_a [8];
    logic [SEL_W-1:0] sel_a [8];

    logic [8*ADR_W-1:0] m_adr;
    logic [8*DAT_W-1:0] m_dat_w;
    logic [8*SEL_W-1:0] m_sel;
    logic [7:0]         m_we, m_cyc, m_stb, gnt;
    logic [DAT_W-1:0]   s_dat_r;
    logic               s_ack, s_err;

    logic [DAT_W-1:0]   m_dat_r;
    logic [7:0]         m_ack, m_err, req;
    logic [ADR_W-1:0]   s_adr;
    logic [DAT_W-1:0]   s_dat_w;
    logic [SEL_W-1:0]   s_sel;
    logic               s_we, s_cyc, s_stb;
    logic [7:0]         wdt_cnt;
    logic [2:0]         wdt_last;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            m_adr[i*ADR_W +: ADR_W]   = adr_a[i];
            m_dat_w[i*DAT_W +: DAT_W] = dat_a[i];
            m_sel[i*SEL_W +: SEL_W]   = sel_a[i];
        end
    end

    conbus_mmux #(
        .ADR_W   (ADR_W),
        .DAT_W   (DAT_W),
        .TIMEOUT (TMO),
        .CNT_W   (CNT_W)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .m_adr     (m_adr),
        .m_dat_w   (m_dat_w),
        .m_sel     (m_sel),
        .m_we      (m_we),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_dat_r   (m_dat_r),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .req       (req),
        .gnt       (gnt),
        .s_adr     (s_adr),
        .s_dat_w   (s_dat_w),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_dat_r   (s_dat_r),
        .s_ack     (s_ack),
        .s_err     (s_err),
        .wdt_cnt   (wdt_cnt),
        .wdt_last  (wdt_last)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] md_mask;
    logic [7:0] md_pgnt;
    bit         md_fire;
    int         md_run;
    int         md_wcnt;
    int         md_last;

    // Expected values for the current cycle
    bit               e_ok;
    int               e_gi;
    logic [7:0]       e_req, e_ack, e_err;
    logic [ADR_W-1:0] e_adr;
    logic [DAT_W-1:0] e_dat;
    logic [SEL_W-1:0] e_sel;
    logic             e_we, e_cyc, e_stb;

    task automatic model_reset();
        md_mask = '0;
        md_pgnt = '0;
        md_fire = 0;
        md_run  = 0;
        md_wcnt = 0;
        md_last = 0;
    endtask

    task automatic model_eval();
        int n;
        n    = 0;
        e_gi = 0;
        for (int i = 0; i < 8; i++) begin
            if (gnt[i]) begin
                n++;
                e_gi = i;
            end
        end
        e_ok  = (n == 1);
        e_req = m_cyc & ~md_mask;
        e_adr = '0; e_dat = '0; e_sel = '0;
        e_we  = 0;  e_cyc = 0;  e_stb = 0;
        e_ack = '0; e_err = '0;
        if (e_ok) begin
            e_adr = adr_a[e_gi];
            e_dat = dat_a[e_gi];
            e_sel = sel_a[e_gi];
            e_we  = m_we[e_gi];
            e_cyc = m_cyc[e_gi] && !md_mask[e_gi];
            e_stb = e_cyc && m_stb[e_gi] && !md_fire;
            if (s_ack && !md_fire) e_ack = gnt;
            if (s_err || md_fire)  e_err = gnt;
        end
    endtask

    // Advance the model over one clock edge; run counts consecutive stalled cycles.
    task automatic model_update();
        bit stalled, nf;
        stalled = e_stb && !s_ack && !s_err && (gnt == md_pgnt);
        nf = 0;
        if (stalled) begin
            md_run++;
            if (md_run == TMO) begin
                nf = 1;
                md_run = 0;
            end
        end else begin
            md_run = 0;
        end
        if (md_fire) begin
            if (e_ok) md_mask[e_gi] = 1'b1;
            md_last = e_gi;
            if (md_wcnt < 255) md_wcnt++;
        end
        md_mask = md_mask & m_cyc;
        md_fire = nf;
        md_pgnt = gnt;
    endtask

    task automatic settle();
        #3;
        model_eval();
        check("req",      req,      e_req);
        check("s_adr",    s_adr,    e_adr);
        check("s_dat_w",  s_dat_w,  e_dat);
        check("s_sel",    s_sel,    e_sel);
        check("s_we",     s_we,     e_we);
        check("s_cyc",    s_cyc,    e_cyc);
        check("s_stb",    s_stb,    e_stb);
        check("m_ack",    m_ack,    e_ack);
        check("m_err",    m_err,    e_err);
        check("m_dat_r",  m_dat_r,  s_dat_r);
        check("wdt_cnt",  wdt_cnt,  md_wcnt);
        check("wdt_last", wdt_last, md_last);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update();
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 8; i++) begin
            adr_a[i] = '0;
            dat_a[i] = '0;
            sel_a[i] = '0;
        end
        m_we = '0; m_cyc = '0; m_stb = '0; gnt = '0;
        s_dat_r = '0; s_ack = 0; s_err = 0;
    endtask

    int hold;

    initial begin
        rst_n = 0;
        clear_inputs();
        model_reset();
        m_cyc = 8'h5A;
        #1;
        settle();
        check("rst_req", req, 8'h5A);
        check("rst_wdt_cnt", wdt_cnt, 0);
        advance();
        cycle();
        rst_n = 1;
        m_cyc = 8'h00;
        cycle();

        // Basic read with ack
        m_cyc = 8'h05; gnt = 8'h01; adr_a[0] = 32'h1000; m_stb = 8'h01;
        settle();
        check("t1_req", req, 8'h05);
        check("t1_s_adr", s_adr, 32'h1000);
        check("t1_s_stb", s_stb, 1);
        advance();
        s_ack = 1; s_dat_r = 32'hCAFE_0001;
        settle();
        check("t1_ack", m_ack, 8'h01);
        check("t1_err", m_err, 8'h00);
        advance();
        s_ack = 0; m_stb = 0; m_cyc = 0;
        cycle();

        // Write from master 2 ending in a slave error
        gnt = 8'h04; m_cyc = 8'h04; m_stb = 8'h04; m_we = 8'h04;
        sel_a[2] = 4'hC; dat_a[2] = 32'hDEADBEEF;
        settle();
        check("t2_we", s_we, 1);
        check("t2_sel", s_sel, 4'hC);
        check("t2_dat", s_dat_w, 32'hDEADBEEF);
        advance();
        s_err = 1;
        settle();
        check("t2_err", m_err, 8'h04);
        advance();
        s_err = 0;
        settle();
        check("t2_req_unmasked", req, 8'h04);
        check("t2_wdt_cnt", wdt_cnt, 0);
        advance();
        m_cyc = 0; m_stb = 0; m_we = 0;
        cycle();

        // Watchdog timeout on master 3
        gnt = 8'h08; m_cyc = 8'h08;
        cycle();
        m_stb = 8'h08;
        for (int k = 0; k < TMO; k++) begin
            settle();
            check("t3_no_err_yet", m_err, 8'h00);
            advance();
        end
        settle();
        check("t3_err_at_tmo", m_err, 8'h08);
        check("t3_stb_low", s_stb, 0);
        advance();
        settle();
        check("t3_req_masked", req, 8'h00);
        check("t3_wdt_cnt", wdt_cnt, 1);
        check("t3_wdt_last", wdt_last, 3);
        advance();
        m_cyc = 0; m_stb = 0;
        cycle();
        m_cyc = 8'h08;
        settle();
        check("t3_req_back", req, 8'h08);
        advance();

        // Watchdog fires alongside a late slave ack
        m_stb = 8'h08;
        for (int k = 0; k < TMO; k++) cycle();
        s_ack = 1;
        settle();
        check("t4_ack_lost", m_ack, 8'h00);
        check("t4_err_wins", m_err, 8'h08);
        advance();
        s_ack = 0; m_stb = 0; m_cyc = 0;
        cycle();

        // Malformed grants block the bus
        m_cyc = 8'hFF; m_stb = 8'hFF; s_ack = 1; s_err = 1;
        gnt = 8'h00;
        settle();
        check("t5_zero_cyc", s_cyc, 0);
        check("t5_zero_ack", m_ack, 8'h00);
        advance();
        gnt = 8'h03;
        settle();
        check("t5_two_stb", s_stb, 0);
        check("t5_two_err", m_err, 8'h00);
        advance();
        s_ack = 0; s_err = 0; m_cyc = 0; m_stb = 0;
        cycle();

        // Asynchronous reset in the middle of a stall with master 3 masked
        gnt = 8'h08; m_cyc = 8'h08;
        cycle();
        m_stb = 8'h08;
        for (int k = 0; k <= TMO; k++) cycle();
        gnt = 8'h02; m_cyc = 8'h0A; m_stb = 8'h0A;
        settle();
        check("t6_mask_pre", req, 8'h02);
        advance();
        for (int k = 0; k < 5; k++) cycle();
        rst_n = 0;
        #1;
        model_reset();
        check("t6_rst_req", req, 8'h0A);
        check("t6_rst_wdt_cnt", wdt_cnt, 0);
        check("t6_rst_last", wdt_last, 0);
        rst_n = 1;
        #0;
        for (int k = 0; k < TMO + 3; k++) cycle();
        m_cyc = 0; m_stb = 0;
        cycle();

        // Randomized traffic
        hold  = 0;
        m_cyc = 8'hFF;
        for (int c = 0; c < 500; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(14, 4);
                if ($urandom_range(99) < 85) gnt = 8'h01 << $urandom_range(7);
                else                         gnt = 8'($urandom);
            end
            hold--;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(19) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] & ($urandom_range(9) != 0);
                m_we[i]  = 1'($urandom);
                adr_a[i] = $urandom;
                dat_a[i] = $urandom;
                sel_a[i] = SEL_W'($urandom);
            end
            s_ack   = ($urandom_range(11) == 0);
            s_err   = ($urandom_range(29) == 0);
            s_dat_r = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
